// File: rtl/seq_divider.sv
// seq_divider - sequential radix-2 restoring divider.
//
// Produces one quotient bit per clock with a single trial subtract. The
// result has C truncating-division semantics: the quotient rounds toward
// zero and the remainder takes the sign of the dividend. This is the
// inverse companion to the sequential signed multiplier and is driven by
// the same start/done controller.
//
// Build option:
//   DIV_SIGNED_EN  defined   -> operands and results are two's complement
//                  undefined -> operands and results are unsigned
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   reset        synchronous, active-high reset
//   start        operation request, only looked at in IDLE
//   dividend     dividend, captured at the accept edge
//   divisor      divisor, captured at the accept edge
//   busy         high in CALC and FIX
//   done         one-cycle pulse while quotient/remainder are valid
//   quotient     result quotient, held until the next accepted start
//   remainder    result remainder, held until the next accepted start
//   div_by_zero  set with done when divisor was zero, held with results
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; results from the last operation are held
// CALC  | one restoring step per cycle, dw cycles in total
// FIX   | apply the result signs to the magnitude quotient/remainder
// DONE  | done pulse for one cycle, then back to IDLE
module seq_divider #(
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [dw-1:0] dividend,
  input  logic [dw-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [dw-1:0] quotient,
  output logic [dw-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = $clog2(dw);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // The partial remainder is always below the divisor magnitude, so dw bits
  // hold it; only the trial difference needs the extra sign bit.
  logic [dw-1:0] prem_q, prem_d;
  // Starts as the dividend magnitude; its MSB is shifted into the partial
  // remainder while quotient bits enter at the bottom.
  logic [dw-1:0] quo_q, quo_d;
  logic [dw-1:0] dvs_q, dvs_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [dw-1:0] quotient_q, quotient_d;
  logic [dw-1:0] remainder_q, remainder_d;
  logic          dbz_q, dbz_d;

  logic          dividend_neg;
  logic          divisor_neg;
  logic [dw-1:0] dividend_mag;
  logic [dw-1:0] divisor_mag;
  logic [dw:0]   shifted;
  logic [dw:0]   trial;

  always_comb begin
`ifdef DIV_SIGNED_EN
    dividend_neg = dividend[dw-1];
    divisor_neg  = divisor[dw-1];
`else
    dividend_neg = 1'b0;
    divisor_neg  = 1'b0;
`endif
    // Negating the most negative value gives 2^(dw-1), which is still the
    // correct magnitude when read as unsigned.
    dividend_mag = dividend_neg ? (~dividend + 1'b1) : dividend;
    divisor_mag  = divisor_neg  ? (~divisor  + 1'b1) : divisor;

    shifted = {prem_q, quo_q[dw-1]};
    trial   = shifted - {1'b0, dvs_q};

    state_d     = state_q;
    cnt_d       = cnt_q;
    prem_d      = prem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          neg_quo_d = dividend_neg ^ divisor_neg;
          neg_rem_d = dividend_neg;
          dbz_d     = 1'b0;
          if (divisor == '0) begin
            state_d     = ST_DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = ST_CALC;
            cnt_d   = CW'(dw - 1);
            prem_d  = '0;
            quo_d   = dividend_mag;
            dvs_d   = divisor_mag;
          end
        end
      end
      ST_CALC: begin
        // A set trial MSB means the subtract went negative: keep the
        // shifted remainder (restore) and emit a 0 quotient bit.
        prem_d = trial[dw] ? shifted[dw-1:0] : trial[dw-1:0];
        quo_d  = {quo_q[dw-2:0], ~trial[dw]};
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_FIX: begin
        quotient_d  = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
        remainder_d = neg_rem_q ? (~prem_q + 1'b1) : prem_q;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      prem_q      <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prem_q      <= prem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Sequential radix-2 restoring divider. It is the inverse companion to the team's sequential signed (Robertson) multiplier.
- Takes a dividend and divisor, iterates one quotient bit per clock using a single trial subtract, and returns quotient and remainder with a start/done handshake.
- Sits beside the multiplier in the lab datapath and is driven by the same controller.

Parameters:
- dw, 8: data width of dividend, divisor, quotient and remainder (dw >= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  dw  dividend, two's complement (unsigned if DIV_SIGNED_EN is undefined).
- divisor  input  dw  divisor, same encoding as dividend.
- busy  output  1  high while an operation is in progress (CALC or FIX).
- done  output  1  one-cycle pulse when quotient/remainder are valid.
- quotient  output  dw  result quotient.
- remainder  output  dw  result remainder.
- div_by_zero  output  1  set with done when divisor == 0; held with the results.

Behaviour:
Reset and operand capture
- One clock; reset is synchronous and active-high (clk, reset).
- reset: state=IDLE; busy, done, div_by_zero=0; quotient, remainder=0; iteration counter=0.
- In IDLE with start=1 the block captures operands at that edge (cycle S):
  - sign_q = sign(dividend) XOR sign(divisor); sign_r = sign(dividend).
  - Internal working values are the magnitudes |dividend|, |divisor| as dw-bit unsigned. |-2^(dw-1)| = 2^(dw-1) fits.
  - div_by_zero is cleared.

States
- IDLE: busy=0. start=1 and divisor!=0 -> CALC with counter=dw-1 and partial remainder P(dw+1 bits)=0. start=1 and divisor==0 -> DONE.
- CALC: busy=1. Each cycle:
  - shift {P,Q} left 1, bringing in the next dividend MSB.
  - trial T = P - |divisor| ((dw+1)-bit).
  - T >= 0 -> P=T, Q[0]=1; otherwise P unchanged, Q[0]=0.
  - counter decrements; at counter==0 -> FIX. Exactly dw CALC cycles.
- FIX: busy=1, one cycle.
  - quotient = sign_q ? -Q : Q.
  - remainder = sign_r ? -P[dw-1:0] : P[dw-1:0].
  - -> DONE.
- DONE: done=1, busy=0, one cycle, -> IDLE. start in DONE is ignored.
- Divide by zero path (IDLE -> DONE directly): quotient = all ones, remainder = dividend unchanged, div_by_zero=1, done at cycle S+1.

Timing and result semantics
- Latency for a normal operation: done high in cycle S+dw+2. busy is high in cycles S+1..S+dw+1.
- Truncating division, C semantics: dividend = quotient*divisor + remainder, with |remainder| < |divisor| and remainder sign equal to the dividend sign (or remainder zero).
- Overflow case -2^(dw-1) / -1: quotient wraps to -2^(dw-1) (0x80 for dw=8), remainder 0, no flag.
- quotient, remainder and div_by_zero hold their values from DONE until the next accepted start. They are not cleared at DONE -> IDLE.
- start while busy or in DONE is ignored, with no queuing. Operand inputs are don't-care except at the accept edge.
- reset mid-operation (any state) aborts at that edge: all outputs return to reset values, no done pulse.

Optional Feature:
- DIV_SIGNED_EN defined: two's-complement signed operation as above.
- DIV_SIGNED_EN undefined: operands are unsigned.
  - sign_q and sign_r are forced to 0, magnitudes equal raw inputs, and FIX passes Q/P through unchanged.
  - FIX remains, so latency is identical (dw+2).
  - Divide by zero still gives quotient all ones, remainder = dividend, div_by_zero=1.

Test Plan:
- dw=8, signed: start with 100/7 -> done exactly at S+10, quotient=14 (0x0E), remainder=2, div_by_zero=0; busy high S+1..S+9.
- Signed sign combos: -100/7 -> q=0xF2 (-14), r=0xFE (-2); 100/-7 -> q=0xF2, r=0x02; -100/-7 -> q=0x0E, r=0xFE.
- Divide by zero: 55/0 -> done at S+1, q=0xFF, r=0x37, div_by_zero=1. Next start 9/3 -> div_by_zero clears, q=3, r=0.
- Boundary: -128/-1 -> q=0x80, r=0. -128/1 -> q=0x80, r=0. 5/9 -> q=0, r=5. Outputs hold after done for 5 idle cycles.
- Handshake/reset: start pulsed again at S+3 during busy -> ignored, single done at S+10. Separate run with reset asserted at S+4 -> no done, all outputs 0, new start accepted next cycle.
- DIV_SIGNED_EN undefined: 200/7 -> q=28 (0x1C), r=4, done at S+10. 0xFF/0x10 -> q=0x0F, r=0x0F.
